// File: rtl/trap_stack_register_bank.sv
// Register bank with dedicated PC/SP slots and a hardware trap stack for nested
// privileged-mode entry. All outputs are registered, and reads are write-first.
module trap_stack_register_bank #(
    parameter int WORD_SIZE            = 32,
    parameter int REG_COUNT            = 16,
    parameter int ADDR_WIDTH           = 4,
    parameter int PC_REGISTER          = 15,
    parameter int SP_REGISTER          = 14,
    parameter int SYSTEM_CALL_REGISTER = 7,
    parameter int TRAP_DEPTH           = 4,
    parameter int SPECREG_LENGTH       = 4,
    parameter int USER_STACK           = 8191,
    parameter int KERNEL_STACK         = 6143,
    parameter int OS_START             = 2048
) (
    input  logic                                slow_clock,
    input  logic                                reset,
    input  logic                                enable,
    input  logic [2:0]                          control,
    input  logic [ADDR_WIDTH-1:0]               register_source_A,
    input  logic [ADDR_WIDTH-1:0]               register_source_B,
    input  logic [ADDR_WIDTH-1:0]               register_Dest,
    input  logic [WORD_SIZE-1:0]                ALU_result,
    input  logic [WORD_SIZE-1:0]                data_from_memory,
    input  logic [WORD_SIZE-1:0]                new_PC,
    input  logic [WORD_SIZE-1:0]                new_SP,
    input  logic [SPECREG_LENGTH-1:0]           special_register,
    output logic [WORD_SIZE-1:0]                read_data_A,
    output logic [WORD_SIZE-1:0]                read_data_B,
    output logic [WORD_SIZE-1:0]                memory_output,
    output logic [WORD_SIZE-1:0]                current_PC,
    output logic [WORD_SIZE-1:0]                current_SP,
    output logic                                kernel_mode,
    output logic [$clog2(TRAP_DEPTH+1)-1:0]     trap_depth,
    output logic                                trap_overflow,
    output logic                                trap_underflow
);

    localparam int DEPTH_W = $clog2(TRAP_DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] PC_IDX  = ADDR_WIDTH'(PC_REGISTER);
    localparam logic [ADDR_WIDTH-1:0] SP_IDX  = ADDR_WIDTH'(SP_REGISTER);
    localparam logic [ADDR_WIDTH-1:0] SYS_IDX = ADDR_WIDTH'(SYSTEM_CALL_REGISTER);
    localparam logic [DEPTH_W-1:0]    DEPTH_MAX = DEPTH_W'(TRAP_DEPTH);

    typedef logic [WORD_SIZE-1:0] bank_t [REG_COUNT];

    bank_t                  bank;
    bank_t                  bank_nx;
    logic [WORD_SIZE-1:0]   frame_pc [TRAP_DEPTH];
    logic [WORD_SIZE-1:0]   frame_sp [TRAP_DEPTH];
    logic [DEPTH_W-1:0]     depth_nx;
    logic                   ovf_nx;
    logic                   unf_nx;
    logic                   push;
    logic                   rd_en;
    logic                   rd_ok;
    logic [WORD_SIZE-1:0]   rd_val;

    function automatic logic [WORD_SIZE-1:0] read_reg(input bank_t regs,
                                                      input logic [ADDR_WIDTH-1:0] idx);
        if (int'(idx) < REG_COUNT)
            return regs[idx];
        return '0;
    endfunction

    always_comb begin
        bank_nx  = bank;
        depth_nx = trap_depth;
        ovf_nx   = trap_overflow;
        unf_nx   = trap_underflow;
        push     = 1'b0;
        rd_en    = 1'b0;
        rd_val   = '0;
        rd_ok    = (int'(register_Dest) < REG_COUNT) &&
                   (register_Dest != PC_IDX) && (register_Dest != SP_IDX);

        case (control)
            3'd1:    begin rd_en = 1'b1; rd_val = ALU_result; end
            3'd2:    begin rd_en = 1'b1; rd_val = data_from_memory; end
            3'd5:    begin rd_en = 1'b1; rd_val = WORD_SIZE'(special_register); end
            default: begin rd_en = 1'b0; rd_val = '0; end
        endcase

        if (enable) begin
            case (control)
                3'd3: begin
                    if (trap_depth < DEPTH_MAX) begin
                        push             = 1'b1;
                        bank_nx[PC_IDX]  = WORD_SIZE'(OS_START);
                        // Only the outermost trap switches stacks; nested traps stay on the kernel stack.
                        if (trap_depth == '0)
                            bank_nx[SP_IDX] = WORD_SIZE'(KERNEL_STACK);
                        bank_nx[SYS_IDX] = ALU_result;
                        depth_nx         = trap_depth + 1'b1;
                    end else begin
                        ovf_nx = 1'b1;
                    end
                end
                3'd4: begin
                    if (trap_depth != '0) begin
                        bank_nx[PC_IDX] = frame_pc[trap_depth - 1'b1];
                        bank_nx[SP_IDX] = frame_sp[trap_depth - 1'b1];
                        depth_nx        = trap_depth - 1'b1;
                    end else begin
                        unf_nx = 1'b1;
                    end
                end
                default: begin
                    bank_nx[PC_IDX] = new_PC;
                    bank_nx[SP_IDX] = new_SP;
                    if (rd_en && rd_ok)
                        bank_nx[register_Dest] = rd_val;
                end
            endcase
        end
    end

    // commit stage: bank, trap stack and registered read outputs share one edge
    always_ff @(posedge slow_clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REG_COUNT; i++)
                bank[i] <= (i == SP_REGISTER) ? WORD_SIZE'(USER_STACK) : '0;
            for (int i = 0; i < TRAP_DEPTH; i++) begin
                frame_pc[i] <= '0;
                frame_sp[i] <= '0;
            end
            trap_depth     <= '0;
            trap_overflow  <= 1'b0;
            trap_underflow <= 1'b0;
            kernel_mode    <= 1'b0;
            read_data_A    <= '0;
            read_data_B    <= '0;
            memory_output  <= '0;
            current_PC     <= '0;
            current_SP     <= WORD_SIZE'(USER_STACK);
        end else begin
            bank <= bank_nx;
            if (push) begin
                frame_pc[trap_depth] <= bank[PC_IDX];
                frame_sp[trap_depth] <= bank[SP_IDX];
            end
            trap_depth     <= depth_nx;
            trap_overflow  <= ovf_nx;
            trap_underflow <= unf_nx;
            kernel_mode    <= (depth_nx != '0);
            read_data_A    <= read_reg(bank_nx, register_source_A);
            read_data_B    <= read_reg(bank_nx, register_source_B);
            memory_output  <= read_reg(bank_nx, register_Dest);
            current_PC     <= bank_nx[PC_IDX];
            current_SP     <= bank_nx[SP_IDX];
        end
    end

endmodule

// File: tb/tb_trap_stack_register_bank.sv
// Directed bench for trap_stack_register_bank: an abstract model (register array plus
// a frame queue) is compared every cycle, alongside hand-computed literal expectations.
module tb_trap_stack_register_bank;

    logic        slow_clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [2:0]  control = '0;
    logic [3:0]  register_source_A = '0, register_source_B = '0, register_Dest = '0;
    logic [31:0] ALU_result = '0, data_from_memory = '0, new_PC = '0, new_SP = '0;
    logic [3:0]  special_register = '0;
    logic [31:0] read_data_A, read_data_B, memory_output, current_PC, current_SP;
    logic        kernel_mode, trap_overflow, trap_underflow;
    logic [2:0]  trap_depth;

    trap_stack_register_bank dut (
        .slow_clock(slow_clock), .reset(reset), .enable(enable), .control(control),
        .register_source_A(register_source_A), .register_source_B(register_source_B),
        .register_Dest(register_Dest), .ALU_result(ALU_result),
        .data_from_memory(data_from_memory), .new_PC(new_PC), .new_SP(new_SP),
        .special_register(special_register), .read_data_A(read_data_A),
        .read_data_B(read_data_B), .memory_output(memory_output),
        .current_PC(current_PC), .current_SP(current_SP), .kernel_mode(kernel_mode),
        .trap_depth(trap_depth), .trap_overflow(trap_overflow),
        .trap_underflow(trap_underflow)
    );

    always #5 slow_clock = ~slow_clock;

    int checks = 0;
    int errors = 0;

    // abstract model state
    logic [31:0] m_regs [16];
    logic [31:0] m_pc, m_sp;
    logic [63:0] m_stack [$];
    logic        m_ovf, m_unf;

    // expected registered outputs
    logic [31:0] e_a, e_b, e_m, e_pc, e_sp;
    logic        e_km, e_ovf, e_unf;
    int          e_depth;
    bit          cmp_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mread(input logic [3:0] idx);
        if (idx == 4'd15) return m_pc;
        if (idx == 4'd14) return m_sp;
        return m_regs[idx];
    endfunction

    task automatic model_reset();
        foreach (m_regs[i]) m_regs[i] = '0;
        m_pc = 0; m_sp = 8191; m_stack.delete(); m_ovf = 0; m_unf = 0;
        e_a = 0; e_b = 0; e_m = 0; e_pc = 0; e_sp = 8191;
        e_km = 0; e_depth = 0; e_ovf = 0; e_unf = 0;
    endtask

    task automatic model_commit();
        logic [63:0] fr;
        if (enable) begin
            if (control == 3'd3) begin
                if (m_stack.size() < 4) begin
                    m_stack.push_back({m_pc, m_sp});
                    m_pc = 2048;
                    if (m_stack.size() == 1) m_sp = 6143;
                    m_regs[7] = ALU_result;
                end else m_ovf = 1;
            end else if (control == 3'd4) begin
                if (m_stack.size() > 0) begin
                    fr = m_stack.pop_back();
                    m_pc = fr[63:32];
                    m_sp = fr[31:0];
                end else m_unf = 1;
            end else begin
                m_pc = new_PC;
                m_sp = new_SP;
                if (register_Dest != 4'd15 && register_Dest != 4'd14) begin
                    if (control == 3'd1) m_regs[register_Dest] = ALU_result;
                    else if (control == 3'd2) m_regs[register_Dest] = data_from_memory;
                    else if (control == 3'd5) m_regs[register_Dest] = {28'd0, special_register};
                end
            end
        end
        e_a = mread(register_source_A);
        e_b = mread(register_source_B);
        e_m = mread(register_Dest);
        e_pc = m_pc; e_sp = m_sp;
        e_depth = m_stack.size();
        e_km = (m_stack.size() != 0);
        e_ovf = m_ovf; e_unf = m_unf;
    endtask

    task automatic step(input logic en, input logic [2:0] ctl, input logic [3:0] sa,
                        input logic [3:0] sb, input logic [3:0] sd, input logic [31:0] alu,
                        input logic [31:0] mem, input logic [31:0] npc,
                        input logic [31:0] nsp, input logic [3:0] spec);
        enable = en; control = ctl; register_source_A = sa; register_source_B = sb;
        register_Dest = sd; ALU_result = alu; data_from_memory = mem;
        new_PC = npc; new_SP = nsp; special_register = spec;
        @(posedge slow_clock);
        model_commit();
        #1;
    endtask

    always @(negedge slow_clock) begin
        if (cmp_en) begin
            check("cyc_read_A", read_data_A, e_a);
            check("cyc_read_B", read_data_B, e_b);
            check("cyc_mem_out", memory_output, e_m);
            check("cyc_pc", current_PC, e_pc);
            check("cyc_sp", current_SP, e_sp);
            check("cyc_depth", 32'(trap_depth), 32'(e_depth));
            check("cyc_kernel", 32'(kernel_mode), 32'(e_km));
            check("cyc_ovf", 32'(trap_overflow), 32'(e_ovf));
            check("cyc_unf", 32'(trap_underflow), 32'(e_unf));
        end
    end

    initial begin
        model_reset();
        repeat (2) @(posedge slow_clock);
        #1;
        check("rst_sp", current_SP, 32'd8191);
        check("rst_pc", current_PC, 32'd0);
        check("rst_depth", 32'(trap_depth), 32'd0);
        check("rst_read_A", read_data_A, 32'd0);
        reset = 1'b1;
        cmp_en = 1;

        step(1, 3'd1, 4'd2, 4'd0, 4'd2, 32'h1234, 0, 32'd1, 32'd8191, 0);
        check("wr_r2_readA", read_data_A, 32'h1234);
        check("wr_r2_pc", current_PC, 32'd1);

        step(1, 3'd1, 4'd15, 4'd2, 4'd15, 32'hDEAD, 0, 32'd4, 32'd8191, 0);
        check("dest_pc_pc", current_PC, 32'd4);
        check("dest_pc_readA", read_data_A, 32'd4);
        step(1, 3'd1, 4'd14, 4'd0, 4'd14, 32'hDEAD, 0, 32'd5, 32'd8000, 0);
        check("dest_sp_sp", current_SP, 32'd8000);

        step(1, 3'd0, 4'd0, 4'd0, 4'd0, 0, 0, 32'h40, 32'd8000, 0);
        step(1, 3'd3, 4'd7, 4'd0, 4'd0, 32'd9, 0, 32'h111, 32'h222, 0);
        check("trap1_pc", current_PC, 32'd2048);
        check("trap1_sp", current_SP, 32'd6143);
        check("trap1_r7", read_data_A, 32'd9);
        check("trap1_km", 32'(kernel_mode), 32'd1);
        check("trap1_depth", 32'(trap_depth), 32'd1);

        step(1, 3'd0, 4'd7, 4'd0, 4'd0, 0, 0, 32'h900, 32'd6100, 0);
        step(1, 3'd3, 4'd7, 4'd0, 4'd0, 32'd10, 0, 0, 0, 0);
        check("trap2_sp", current_SP, 32'd6100);
        check("trap2_depth", 32'(trap_depth), 32'd2);
        step(1, 3'd4, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0);
        check("ret1_pc", current_PC, 32'h900);
        check("ret1_sp", current_SP, 32'd6100);
        step(1, 3'd4, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0);
        check("ret2_pc", current_PC, 32'h40);
        check("ret2_sp", current_SP, 32'd8000);
        check("ret2_km", 32'(kernel_mode), 32'd0);

        for (int i = 0; i < 5; i++)
            step(1, 3'd3, 4'd7, 4'd0, 4'd0, 32'(20 + i), 0, 0, 0, 0);
        check("ovf_depth", 32'(trap_depth), 32'd4);
        check("ovf_flag", 32'(trap_overflow), 32'd1);
        check("ovf_pc", current_PC, 32'd2048);
        check("ovf_sp", current_SP, 32'd6143);
        check("ovf_r7", read_data_A, 32'd23);
        for (int i = 0; i < 4; i++)
            step(1, 3'd4, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0);
        check("unwind_pc", current_PC, 32'h40);
        step(1, 3'd4, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0);
        check("unf_flag", 32'(trap_underflow), 32'd1);
        check("unf_pc", current_PC, 32'h40);
        check("unf_sp", current_SP, 32'd8000);

        step(1, 3'd5, 4'd3, 4'd0, 4'd3, 0, 0, 32'h44, 32'd8000, 4'b1010);
        check("spec_r3", read_data_A, 32'h0000000A);
        step(0, 3'd1, 4'd3, 4'd2, 4'd3, 32'hFFFF, 0, 32'h99, 32'd1, 0);
        check("hold_r3", read_data_A, 32'h0000000A);
        check("hold_readB", read_data_B, 32'h1234);
        check("hold_pc", current_PC, 32'h44);
        step(1, 3'd2, 4'd0, 4'd5, 4'd5, 0, 32'hCAFE, 32'h48, 32'd8000, 0);
        check("mem_r5", read_data_B, 32'hCAFE);
        check("mem_out_r5", memory_output, 32'hCAFE);
        step(1, 3'd1, 4'd0, 4'd0, 4'd0, 32'h77, 0, 32'h4C, 32'd8000, 0);
        check("ext_r0_mem_out", memory_output, 32'h77);

        step(1, 3'd3, 4'd0, 4'd0, 4'd0, 32'd1, 0, 0, 0, 0);
        step(1, 3'd3, 4'd0, 4'd0, 4'd0, 32'd2, 0, 0, 0, 0);
        check("pre_rst_depth", 32'(trap_depth), 32'd2);
        cmp_en = 0;
        reset = 1'b0;
        #1;
        check("arst_depth", 32'(trap_depth), 32'd0);
        check("arst_km", 32'(kernel_mode), 32'd0);
        check("arst_ovf", 32'(trap_overflow), 32'd0);
        check("arst_unf", 32'(trap_underflow), 32'd0);
        check("arst_sp", current_SP, 32'd8191);
        check("arst_pc", current_PC, 32'd0);
        @(posedge slow_clock);
        #1;
        reset = 1'b1;
        model_reset();
        cmp_en = 1;
        step(1, 3'd0, 4'd3, 4'd5, 4'd2, 0, 0, 32'd8, 32'd8191, 0);
        check("post_rst_r3", read_data_A, 32'd0);
        check("post_rst_r5", read_data_B, 32'd0);
        step(1, 3'd3, 4'd7, 4'd0, 4'd0, 32'd3, 0, 0, 0, 0);
        check("post_rst_trap_sp", current_SP, 32'd6143);
        @(negedge slow_clock);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/trap_stack_register_bank.md
# trap_stack_register_bank

Parametrised, single-clock successor to the processor register bank. It holds REG_COUNT general registers with dedicated PC/SP slots and the same control encodings. Its privileged-mode entry uses a hardware trap stack of TRAP_DEPTH frames, so system calls can nest and return in order instead of sharing a single keeper-register pair. It sits between decode/ALU/memory and the fetch unit and supplies operands, store data, PC and SP.

## Interface
- WORD_SIZE, 32, register width
- REG_COUNT, 16, number of architectural registers (2..2^ADDR_WIDTH)
- ADDR_WIDTH, 4, register index width
- PC_REGISTER, 15, PC index
- SP_REGISTER, 14, SP index
- SYSTEM_CALL_REGISTER, 7, receives the syscall code on trap entry
- TRAP_DEPTH, 4, trap stack frames (1..16)
- SPECREG_LENGTH, 4, special-register width
- USER_STACK, 8191, SP reset value
- KERNEL_STACK, 6143, SP loaded on outermost trap
- OS_START, 2048, PC loaded on trap entry

Ports:
- slow_clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low
- enable  in  1  commit enable
- control  in  3  operation select
- register_source_A, register_source_B, register_Dest  in  ADDR_WIDTH each  indices
- ALU_result, data_from_memory, new_PC, new_SP  in  WORD_SIZE each
- special_register  in  SPECREG_LENGTH
- read_data_A, read_data_B, memory_output  out  WORD_SIZE  registered reads of A, B, Dest
- current_PC, current_SP  out  WORD_SIZE  registered PC/SP
- kernel_mode  out  1  high while trap_depth > 0
- trap_depth  out  clog2(TRAP_DEPTH+1)  frames in use
- trap_overflow, trap_underflow  out  1  sticky error flags

## Operation
- Reset (reset low) clears all bank entries to 0 except SP, which is set to USER_STACK.
- Reset also clears the trap stack, trap_depth, kernel_mode and both flags, and sets all outputs to 0 except current_SP, which becomes USER_STACK.
- With enable low, the bank, trap stack and flags hold. Read outputs still update.
- Operations with enable high. "RD write" means a write to register_Dest, suppressed when register_Dest is PC, SP, or ≥ REG_COUNT.
  - Control 1: RD write of ALU_result; PC←new_PC; SP←new_SP.
  - Control 2: RD write of data_from_memory; PC←new_PC; SP←new_SP.
  - Control 5: RD write of special_register, zero-extended; PC←new_PC; SP←new_SP.
  - Control 0, 6, 7: PC←new_PC; SP←new_SP only.
- Control 3, trap entry, when trap_depth < TRAP_DEPTH:
  - Push {PC, SP} into frame[trap_depth].
  - PC←OS_START.
  - SP←KERNEL_STACK if trap_depth == 0, otherwise SP is unchanged (nested trap keeps the kernel stack).
  - SYSTEM_CALL_REGISTER←ALU_result.
  - trap_depth increments.
- Control 3 when trap_depth == TRAP_DEPTH: no state change except trap_overflow←1.
- Control 4, trap return, when trap_depth > 0: pop {PC, SP} from frame[trap_depth-1] and decrement trap_depth.
- Control 4 when trap_depth == 0: no state change except trap_underflow←1.
- kernel_mode is (trap_depth != 0), registered and consistent with trap_depth every cycle.
- Flags clear only on reset.
- Reads of an index ≥ REG_COUNT return 0.

## Timing
- All outputs are registered and update on the same rising edge as the commit.
- Reads are write-first. Outputs at edge N reflect the indices presented before edge N and the bank state including the commit at edge N.
- Examples: a write to r3 with register_source_A=3 makes read_data_A show the new value immediately after the edge. current_PC after a trap edge shows OS_START.
- Commit-to-visibility latency is 0 extra cycles; index-to-output latency is 1 cycle.
- Back-to-back traps or returns on consecutive cycles are legal. Each one consumes or releases exactly one frame.
- Asynchronous reset asserted mid-operation discards any in-flight commit. The first commit happens on the first rising edge after reset deasserts.

## Test plan
- Reset, then release → current_SP=8191, current_PC=0, trap_depth=0, all read data 0. Write r2←0x1234 (control 1, new_PC=1) with source_A=2 → read_data_A=0x1234 and current_PC=1 after the same edge.
- Control 1 with register_Dest=15, ALU_result=0xDEAD, new_PC=4 → PC=4, 0xDEAD discarded. Repeat with Dest=14 → SP=new_SP, not ALU_result.
- Trap from PC=0x40, SP=8000 with ALU_result=9 → PC=2048, SP=6143, r7=9, kernel_mode=1, depth=1. A nested trap at PC=0x900, SP=6100 → SP stays 6100, depth=2. Two returns → PC/SP = 0x900/6100, then 0x40/8000, kernel_mode=0.
- TRAP_DEPTH=4: five traps → depth=4, trap_overflow=1, PC/SP unchanged by the fifth trap. A return at depth 0 → trap_underflow=1, no state change.
- Control 5 with special_register=4'b1010, Dest=3 → r3=0x0000000A.
- Assert reset mid-sequence at depth=2 → depth=0, kernel_mode=0, flags 0, SP=8191 asynchronously, before the next edge.
